// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding
// and port index constants.
package mem_arb_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Burst counter width; large enough for the full legal MAX_BURST range.
    localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one combinational-read memory between the
// CPU (port 0) and the boot loader / DMA (port 1). One access per grant,
// optional locked bursts capped at MAX_BURST consecutive grants.
//
// state | meaning
// IDLE  | no grant; pick owner from pending requests (prio breaks ties)
// GNT   | drive memory from owner; write commits / read captured at edge
// RESP  | ack to owner; continue locked burst or return to IDLE
module memory_arbiter
    import mem_arb_defs::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 we0,
    input  logic                 lock0,
    input  logic [BUS_WIDTH-1:0] addr0,
    input  logic [BUS_WIDTH-1:0] wdata0,
    output logic [BUS_WIDTH-1:0] rdata0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic                 lock1,
    input  logic [BUS_WIDTH-1:0] addr1,
    input  logic [BUS_WIDTH-1:0] wdata1,
    output logic [BUS_WIDTH-1:0] rdata1,
    output logic                 ack1,
    output logic                 mem_we,
    output logic [BUS_WIDTH-1:0] mem_a,
    output logic [BUS_WIDTH-1:0] mem_wd,
    input  logic [BUS_WIDTH-1:0] mem_rd
);

    localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_BURST);

    arb_state_e             state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   prio_q, prio_d;
    logic [BURST_CNT_W-1:0] burst_q, burst_d;
    logic                   ack0_q, ack0_d;
    logic                   ack1_q, ack1_d;
    logic [BUS_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [BUS_WIDTH-1:0]   rdata1_q, rdata1_d;

    logic                   req_own;
    logic                   we_own;
    logic                   lock_own;
    logic [BUS_WIDTH-1:0]   addr_own;
    logic [BUS_WIDTH-1:0]   wdata_own;

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

    // Owner mux: select the granted port's request fields.
    always_comb begin
        if (owner_q == PORT_DMA) begin
            req_own   = req1;
            we_own    = we1;
            lock_own  = lock1;
            addr_own  = addr1;
            wdata_own = wdata1;
        end else begin
            req_own   = req0;
            we_own    = we0;
            lock_own  = lock0;
            addr_own  = addr0;
            wdata_own = wdata0;
        end
    end

    // Next-state, memory drive and response capture.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        burst_d  = burst_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        mem_we   = 1'b0;
        mem_a    = '0;
        mem_wd   = '0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = GNT;
                    burst_d = '0;
                    if (req0 && req1) begin
                        owner_d = prio_q;
                    end else begin
                        owner_d = req1 ? PORT_DMA : PORT_CPU;
                    end
                end
            end
            GNT: begin
                mem_a   = addr_own;
                mem_wd  = wdata_own;
                // Reset must block the write that would commit on this edge.
                mem_we  = we_own & ~rst;
                if (owner_q == PORT_DMA) begin
                    rdata1_d = mem_rd;
                    ack1_d   = 1'b1;
                end else begin
                    rdata0_d = mem_rd;
                    ack0_d   = 1'b1;
                end
                prio_d  = ~owner_q;
                burst_d = burst_q + 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (lock_own && req_own && (burst_q < BURST_MAX)) begin
                    state_d = GNT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= PORT_CPU;
            prio_q   <= PORT_CPU;
            burst_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            burst_q  <= burst_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single unified byte-addressed memory between two requesters: port 0 (multicycle CPU) and port 1 (boot loader / DMA).
- Round-robin arbitration with req/ack handshake and an optional locked burst.
- Sits directly in front of `memory` and drives its WE/A/WD; it consumes its combinational RD.
- One memory access per grant; the memory write commits on the clock edge that ends the grant cycle.

Parameters:
- BUS_WIDTH, 32: width of address, write data and read data on all ports.
- MAX_BURST, 16: maximum consecutive locked grants to one port before forced re-arbitration; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 transaction request; hold stable until ack0.
- we0  in  1  port 0 write enable; 0 means read.
- lock0  in  1  port 0 requests to keep the grant for its next transaction.
- addr0  in  BUS_WIDTH  port 0 byte address.
- wdata0  in  BUS_WIDTH  port 0 write data.
- rdata0  out  BUS_WIDTH  port 0 read data, registered.
- ack0  out  1  port 0 completion strobe, registered, 1 cycle.
- req1, we1, lock1, addr1, wdata1, rdata1, ack1: same as port 0, for port 1.
- mem_we  out  1  to memory WE.
- mem_a  out  BUS_WIDTH  to memory A.
- mem_wd  out  BUS_WIDTH  to memory WD.
- mem_rd  in  BUS_WIDTH  from memory RD (combinational read).

Behaviour:
- Clock and reset: one clock domain (clk); rst is synchronous and active-high.
- Reset values:
  - state=IDLE, prio=0, owner=0, burst_cnt=0.
  - ack0=ack1=0, rdata0=rdata1=0.
  - mem_we forced 0 combinationally while rst=1, including mid-grant, so no write commits on the reset edge.
- States: IDLE, GNT, RESP. Registered `owner` selects the port.
- IDLE:
  - No req: stay in IDLE.
  - One req: owner<=that port, go to GNT.
  - Both req: owner<=prio, go to GNT.
  - burst_cnt<=0 on leaving IDLE.
- GNT (exactly 1 cycle):
  - mem_a=addr_owner, mem_wd=wdata_owner, mem_we=we_owner.
  - At the edge: rdata_owner<=mem_rd, ack_owner<=1, prio<=~owner, burst_cnt<=burst_cnt+1. Go to RESP.
  - rdata is captured on writes too; it then holds pre-write contents.
- RESP (ack_owner=1 this cycle):
  - The requester may drop req or present its next transaction.
  - If lock_owner && req_owner && burst_cnt<MAX_BURST: go to GNT, same owner.
  - Else go to IDLE.
  - Other port's req is ignored in RESP.
- Non-GNT states: mem_we=0, mem_a=0, mem_wd=0.
- rdata of the non-owner port holds its value.
- Latency:
  - Unlocked access: req -> ack is 2 cycles from IDLE (IDLE, GNT, ack in RESP); throughput 1 per 3 cycles.
  - Locked burst: 1 access per 2 cycles.
- Starvation bound: after MAX_BURST locked grants the FSM returns to IDLE; prio already points at the other port, so a pending other req wins.
- Address: passed through unmodified; no alignment check. Wrap-around beyond 64 KiB is the memory's behaviour.
- req dropped before grant (contract violation): if dropped while in IDLE, no access. Once in GNT the access completes regardless.

Decomposition:
- Shared package/include `mem_arb_defs`:
  - state encoding localparams: IDLE=2'd0, GNT=2'd1, RESP=2'd2.
  - port index constants: PORT_CPU=0, PORT_DMA=1.
- Single module; no sub-module needed.
- The owner mux is inline combinational logic.

Test Plan:
- Read: mem[0x10..0x13] preloaded 0xDEADBEEF; req0=1, we0=0, addr0=0x10. Expect GNT on cycle 1 with mem_a=0x10, mem_we=0; ack0=1 and rdata0=0xDEADBEEF on cycle 2; ack1 stays 0.
- Write: req1=1, we1=1, addr1=0x20, wdata1=0x12345678. Expect mem_we high exactly 1 cycle. A following read of 0x20 on port 0 returns 0x12345678.
- Contention: req0 and req1 both held high from reset, unlocked, each re-requesting after ack. Grant order is 0,1,0,1; each ack spaced 3 cycles apart.
- Burst cap: MAX_BURST=4; lock0=1, req0 continuous, req1 pending. Expect 4 port-0 acks 2 cycles apart, then IDLE, then port 1 granted.
- Lock release: lock0=0 in the first RESP while req1 pending. Next state IDLE, then port 1 granted.
- Reset mid-write: rst=1 during GNT of a port-1 write to 0x40 (old value 0x0). Expect mem_we=0 that cycle and mem[0x40] still 0x0. Next cycle: state IDLE, ack1=0, rdata1=0.
